// File: rtl/fb_scanout_fetch.sv
`default_nettype none
// ============================================================================
// fb_scanout_fetch : DDR frame-buffer burst reader feeding the VGA pixel stream
// Revision 1.0
// ============================================================================
module fb_scanout_fetch #(
    parameter logic [29:0] FB_BASE    = 30'd5242880,
    parameter int          BURST      = 32,
    parameter int          FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_calib_done,
    input  logic [20:0] total_pixels,
    input  logic        frame_sync,
    input  logic        cmd_full,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    output logic        cmd_en,
    input  logic [31:0] rd_data,
    input  logic [6:0]  rd_count,
    input  logic        rd_empty,
    output logic        rd_en,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        underrun,
    output logic        frame_done
);

    localparam logic [6:0] c_burst = 7'(BURST);
    localparam logic [7:0] c_depth = 8'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_WAIT_CAL = 3'd0,
        S_ARM      = 3'd1,
        S_STREAM   = 3'd2,
        S_GAP      = 3'd3,
        S_FLUSH    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_calib_s1, r_calib_s2;
    logic [20:0] r_tp, r_req_words, r_sent;
    logic [6:0]  r_committed;

    logic [20:0] w_remain;
    logic [6:0]  w_amount;
    logic        w_fits;
    logic        w_issue, w_reload, w_take_sync;
    logic        w_pix_valid, w_rd_en, w_stream_pop, w_starve;
    logic        w_unused;

    assign w_remain = r_tp - r_req_words;
    assign w_amount = (w_remain >= 21'(BURST)) ? c_burst : w_remain[6:0];
    // Words still in flight count against the FIFO so the port can never overflow.
    assign w_fits   = ({1'b0, r_committed} + {1'b0, w_amount}) <= c_depth;

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_reload     = 1'b0;
        w_take_sync  = 1'b0;
        w_pix_valid  = 1'b0;
        w_rd_en      = 1'b0;
        w_starve     = 1'b0;
        case (r_state)
            S_WAIT_CAL: begin
                if (r_calib_s2) w_state_next = S_ARM;
            end
            S_ARM, S_DONE: begin
                if (frame_sync) begin
                    w_take_sync  = 1'b1;
                    w_reload     = 1'b1;
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM, S_GAP: begin
                w_pix_valid = !rd_empty && (r_sent < r_tp);
                w_rd_en     = w_pix_valid && pix_ready;
                w_starve    = pix_ready && rd_empty && (r_sent < r_tp);
                if (frame_sync) begin
                    w_take_sync  = 1'b1;
                    w_state_next = S_FLUSH;
                end else if ((r_sent == r_tp) && (r_committed == 7'd0)) begin
                    w_state_next = S_DONE;
                end else if ((r_state == S_STREAM) && (r_req_words < r_tp) &&
                             !cmd_full && w_fits) begin
                    w_issue      = 1'b1;
                    w_state_next = S_GAP;
                end else if (r_state == S_GAP) begin
                    w_state_next = S_STREAM;
                end
            end
            S_FLUSH: begin
                // Discard every word of the abandoned frame before restarting at pixel 0.
                w_rd_en = !rd_empty && (r_committed != 7'd0);
                if (r_committed == 7'd0) begin
                    w_reload     = 1'b1;
                    w_state_next = S_STREAM;
                end
            end
            default: w_state_next = S_WAIT_CAL;
        endcase
    end

    assign w_stream_pop = w_pix_valid && pix_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_WAIT_CAL;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_calib_s1    <= 1'b0;
            r_calib_s2    <= 1'b0;
            r_tp          <= '0;
            r_req_words   <= '0;
            r_sent        <= '0;
            r_committed   <= '0;
            cmd_en        <= 1'b0;
            cmd_bl        <= '0;
            cmd_byte_addr <= '0;
            underrun      <= 1'b0;
        end else begin
            r_calib_s1  <= mem_calib_done;
            r_calib_s2  <= r_calib_s1;
            cmd_en      <= w_issue;
            r_committed <= r_committed + (w_issue ? w_amount : 7'd0) - {6'd0, w_rd_en};
            if (w_take_sync) r_tp <= total_pixels;
            if (w_issue) begin
                cmd_bl        <= 6'(w_amount - 7'd1);
                cmd_byte_addr <= FB_BASE + 30'({r_req_words, 2'b00});
            end
            if (w_reload) begin
                r_req_words <= '0;
                r_sent      <= '0;
                underrun    <= 1'b0;
            end else begin
                if (w_issue)      r_req_words <= r_req_words + 21'(w_amount);
                if (w_stream_pop) r_sent      <= r_sent + 21'd1;
                if (w_starve)     underrun    <= 1'b1;
            end
        end
    end

    assign cmd_instr  = 3'b001;
    assign rd_en      = w_rd_en;
    assign pix_valid  = w_pix_valid;
    assign pix_data   = rd_data[23:0];
    assign frame_done = (r_state == S_DONE);
    assign w_unused   = ^{rd_count, rd_data[31:24]};

endmodule
`default_nettype wire

// File: doc/fb_scanout_fetch.md
# fb_scanout_fetch

Frame-buffer scanout fetcher sitting directly downstream of the colour-mapping stage: it reads the 24-bit colour words written into the frame-buffer region of DDR through one MCB-style read port and streams them, in raster order, to the VGA timing/output stage. It keeps the port's 64-word read FIFO topped up with bursts, restarts cleanly on each frame sync, and flags underruns.

## Interface
- FB_BASE, 30'd5242880, byte address of pixel 0 in the frame buffer
- BURST, 32, maximum words per read command (1..64)
- FIFO_DEPTH, 64, read-data FIFO depth of the memory port
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- mem_calib_done  in  1  DDR calibration complete (async; 2-flop synchronised internally)
- total_pixels  in  21  pixels per frame (307200..1310720); sampled on accepted frame_sync
- frame_sync  in  1  one-cycle pulse from display timing, start of a new frame
- cmd_full  in  1  command FIFO full
- cmd_instr  out  3  always 3'b001 (read)
- cmd_bl  out  6  burst length minus one
- cmd_byte_addr  out  30  burst start byte address
- cmd_en  out  1  one-cycle command strobe
- rd_data  in  32  read FIFO head word
- rd_count  in  7  read FIFO occupancy
- rd_empty  in  1  read FIFO empty
- rd_en  out  1  read FIFO pop
- pix_data  out  24  pixel colour, = rd_data[23:0]
- pix_valid  out  1  pix_data valid this cycle
- pix_ready  in  1  display consumes pixel when pix_valid & pix_ready
- underrun  out  1  sticky: pix_ready high while stream active and FIFO empty
- frame_done  out  1  high once all total_pixels delivered, until next frame_sync

## Operation
- States: WAIT_CAL, ARM, STREAM, GAP, FLUSH, DONE.
- Reset: state WAIT_CAL; cmd_en, rd_en, pix_valid, underrun, frame_done = 0; cmd_instr = 3'b001; cmd_bl, cmd_byte_addr = 0; counters = 0.
- WAIT_CAL -> ARM when synchronised calib high. ARM -> STREAM on frame_sync: latch total_pixels into tp, req_words = 0, sent = 0, committed = 0, underrun = 0.
- committed (7 bits) = words requested minus words popped; +amount on cmd_en, -1 on each rd_en, both same cycle allowed.
- amount = min(BURST, tp - req_words), 7-bit. Issue in STREAM when req_words < tp, !cmd_full, committed + amount <= FIFO_DEPTH: cmd_bl = amount-1, cmd_byte_addr = FB_BASE + (req_words << 2), cmd_en = 1, req_words += amount, go GAP. GAP: cmd_en = 0, back to STREAM next cycle.
- Stream path (STREAM/GAP): pix_valid = !rd_empty & (sent < tp); rd_en = pix_valid & pix_ready; sent increments per pop. underrun set when pix_ready & rd_empty & sent < tp.
- sent == tp (and committed == 0) -> DONE, frame_done = 1; frame_sync in DONE behaves as in ARM.
- frame_sync while STREAM/GAP: go FLUSH. FLUSH: no commands, pix_valid = 0, rd_en = !rd_empty until committed == 0, then reload as ARM and enter STREAM. frame_sync during FLUSH ignored (reload already pending).

## Timing
- cmd_en exactly one cycle; minimum two cycles between commands.
- First command no earlier than the cycle after frame_sync; pix_valid combinational from rd_empty, zero added latency.
- total_pixels not multiple of BURST: final burst shorter (e.g. tp=307200, BURST=32 exact; tp=100 -> 32,32,32,4).
- Reset asserted mid-burst: all outputs to reset values immediately; in-flight data is not tracked (memory controller reset together).
- cmd_full high: issue stalls, stream continues.

## Test plan
- calib low 100 cycles, frame_sync pulses -> no cmd_en; after calib + frame_sync, first cmd_bl=31, addr=5242880, second addr=5243008.
- tp=100, pix_ready constant 1, model returns data 20 cycles after cmd -> bursts 32,32,32,4 (cmd_bl 31,31,31,3), exactly 100 pixels in order, frame_done=1, committed never >64.
- pix_ready 0 for 500 cycles -> at most 64 words committed, no cmd_en once full, no underrun; resume delivers all pixels.
- Memory latency 200 cycles, pix_ready=1 -> underrun=1, pixel order intact; next frame_sync clears underrun.
- frame_sync after 50 of 307200 pixels -> no further commands, FIFO drained to committed=0, next cmd addr=5242880, pixel 0 re-delivered.
- Assert reset (0) mid-STREAM -> cmd_en, rd_en, pix_valid, frame_done 0 same cycle; state WAIT_CAL.
